// File: rtl/addr_rd_pkg.sv
// Shared types and helpers for the address-driven RAM read buffer.
package addr_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int STAT_W = 16;

  // RAM address width; a single-word RAM still needs one address bit.
  function automatic int ma_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/addr_rd_fifo.sv
// Synchronous FIFO buffering RAM words; push and pop may coincide at any occupancy.
module addr_rd_fifo #(
  parameter  int DATA_WIDTH = 16,
  parameter  int FIFO_DEPTH = 4,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [CW-1:0]         count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO can still take a word if the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/addr_rd_buffer.sv
// Reads RAM at each generated address, buffers words in a FIFO and reports run completion.
// Optional build macro ADDR_RD_STATS_EN adds rd_count/drop_count statistics outputs.
module addr_rd_buffer
  import addr_rd_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 16,
  parameter  int MEM_DEPTH  = 64,
  parameter  int FIFO_DEPTH = 4,
  localparam int MA         = ma_width(MEM_DEPTH),
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  addr_ovf,
  input  logic                  addr_vld,
  input  logic                  addr_last,
  output logic                  addr_rdy,
  output logic                  mem_en,
  output logic [MA-1:0]         mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_vld,
  input  logic                  dout_rdy,
  output logic                  err_range,
  output logic                  done,
`ifdef ADDR_RD_STATS_EN
  output logic [STAT_W-1:0]     rd_count,
  output logic [STAT_W-1:0]     drop_count,
`endif
  output state_t                state_dbg_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never waits on ready, and the addr/dout payloads are only meaningful while valid.

  state_t        state_q, state_d;
  logic          inflight_q;
  logic          err_q, err_d;
  logic          accept, legal, start_run, drain_done;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   used;

  // Credits: every word in the FIFO or in flight reserves a slot, so pushes never overflow.
  assign used       = {1'b0, fifo_count} + (CW+1)'(inflight_q);
  assign addr_rdy   = (state_q == RUN) && !fifo_full && (used < (CW+1)'(FIFO_DEPTH));
  assign accept     = addr_vld && addr_rdy;
  assign legal      = !addr_ovf && (addr_in < ADDR_WIDTH'(MEM_DEPTH));
  assign mem_en     = accept && legal;
  assign mem_addr   = mem_en ? addr_in[MA-1:0] : '0;
  assign start_run  = (state_q == IDLE) && start;
  assign drain_done = (state_q == DRAIN) && !inflight_q && fifo_empty;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && addr_last) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start_run)           err_d = 1'b0;
    else if (accept && !legal) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= mem_en;
      err_q      <= err_d;
    end
  end

  addr_rd_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .push_i (inflight_q),
    .pop_i  (dout_rdy),
    .wdata_i(mem_rdata),
    .rdata_o(dout),
    .count_o(fifo_count),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign dout_vld    = !fifo_empty;
  assign err_range   = err_q;
  assign done        = drain_done;
  assign state_dbg_o = state_q;

`ifdef ADDR_RD_STATS_EN
  logic [STAT_W-1:0] rd_cnt_q, drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn || start_run) begin
      rd_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (mem_en && (rd_cnt_q != '1))              rd_cnt_q   <= rd_cnt_q + STAT_W'(1);
      if (accept && !legal && (drop_cnt_q != '1))  drop_cnt_q <= drop_cnt_q + STAT_W'(1);
    end
  end

  assign rd_count   = rd_cnt_q;
  assign drop_count = drop_cnt_q;
`endif

endmodule
